// File: rtl/mem_stage.sv
// Memory-access pipeline stage: word loads/stores over an ack-based data bus, stall/bubble control, MEM forwarding and the MEM/WB register.
// Optional build macro MEM_TIMEOUT_EN adds a WAIT-state timeout that aborts the access and sets a sticky bus_err.
module mem_stage #(
    parameter int ADDR_W         = 30,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              MEM_CTRL,
    input  logic [4:0]        WB_CTRL,
    input  logic [68:0]       MEM_DATA,
    output logic              dm_req,
    output logic              dm_we,
    output logic [ADDR_W-1:0] dm_addr,
    output logic [31:0]       dm_wdata,
    input  logic [31:0]       dm_rdata,
    input  logic              dm_ack,
    output logic              mem_stall,
    output logic [37:0]       MEM_BACK,
    output logic [4:0]        o_WB_CTRL,
    output logic [68:0]       o_WB_DATA,
    output logic              bus_err
);

    typedef enum logic {
        S_IDLE,
        S_WAIT
    } state_t;

    state_t state, state_n;

    logic [4:0]  rw;
    logic [31:0] alu_out;
    logic [31:0] store_data;
    logic        is_store;
    logic        is_load;
    logic        access;
    logic        fwd_we;
    logic        timeout;

    assign rw         = MEM_DATA[68:64];
    assign alu_out    = MEM_DATA[63:32];
    assign store_data = MEM_DATA[31:0];

    // A store wins when both memWrite and memToReg are set, so such an op never returns load data.
    assign is_store = MEM_CTRL;
    assign is_load  = WB_CTRL[3] & ~MEM_CTRL;
    assign access   = MEM_CTRL | WB_CTRL[3];

    // Loads are never forwarded from this stage; their data only exists in WB.
    assign fwd_we   = WB_CTRL[4] & ~WB_CTRL[3];
    assign MEM_BACK = {fwd_we, rw, alu_out};

    assign dm_addr  = alu_out[ADDR_W+1:2];
    assign dm_wdata = store_data;

    function automatic logic [31:0] load_word(input logic load, input logic [31:0] rdata);
        return load ? rdata : 32'h0;
    endfunction

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("mem_stage: TIMEOUT_CYCLES must be at least 1");
    end

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

    logic [CNT_W-1:0] wait_cnt;
    logic             bus_err_q;

    // The abort fires in the TIMEOUT_CYCLES-th WAIT cycle; an ack in that same cycle still completes.
    assign timeout = (state == S_WAIT) & access & ~dm_ack
                     & (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt <= '0;
        end else if (state == S_WAIT && access && !dm_ack && !timeout) begin
            wait_cnt <= wait_cnt + 1'b1;
        end else begin
            wait_cnt <= '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus_err_q <= 1'b0;
        end else if (timeout) begin
            bus_err_q <= 1'b1;
        end
    end

    assign bus_err = bus_err_q;
`else
    assign timeout = 1'b0;
    assign bus_err = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n   = state;
        dm_req    = 1'b0;
        dm_we     = 1'b0;
        mem_stall = 1'b0;
        case (state)
            S_IDLE: begin
                dm_req    = access;
                dm_we     = access & is_store;
                mem_stall = access & ~dm_ack;
                if (access && !dm_ack) begin
                    state_n = S_WAIT;
                end
            end
            S_WAIT: begin
                dm_req    = access;
                dm_we     = access & is_store;
                mem_stall = access & ~dm_ack & ~timeout;
                if (!access || dm_ack || timeout) begin
                    state_n = S_IDLE;
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    // MEM/WB boundary: stalled or aborted cycles send a bubble; data holds its last committed value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_WB_CTRL <= 5'b0;
            o_WB_DATA <= 69'b0;
        end else if (mem_stall || timeout) begin
            o_WB_CTRL <= 5'b0;
        end else begin
            o_WB_CTRL <= WB_CTRL;
            o_WB_DATA <= {rw, alu_out, load_word(is_load, dm_rdata)};
        end
    end

endmodule
